// File: rtl/pdm_pkg.sv
// Shared PCM definitions for the pdm modulator and pddm demodulator.
package pdm_pkg;
  localparam int DW = 32;
  typedef logic [DW-1:0] pcm_t;
  localparam pcm_t SIGN_FLIP = {1'b1, {(DW-1){1'b0}}};
endpackage

// File: rtl/pdm_edge_sync.sv
// Rising-edge pulse generator for a slow strobe; with PDM_INPUT_SYNC_EN the
// input first crosses a SYNC_STAGES-flop synchronizer.
module pdm_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic pulse
);
`ifdef PDM_INPUT_SYNC_EN
  localparam int NS = SYNC_STAGES;
`else
  localparam int NS = 0;
`endif

  // sr_q[NS] is the current registered level; lower bits are synchronizer stages
  logic [NS:0] sr_q;
  logic        prev_q;

  if (NS == 0) begin : g_nosync
    always_ff @(posedge clk or negedge rstn)
      if (!rstn) sr_q <= '0;
      else       sr_q <= d;
  end else begin : g_sync
    always_ff @(posedge clk or negedge rstn)
      if (!rstn) sr_q <= '0;
      else       sr_q <= {sr_q[NS-1:0], d};
  end

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) prev_q <= 1'b0;
    else       prev_q <= sr_q[NS];

  assign pulse = sr_q[NS] & ~prev_q;
endmodule

// File: rtl/pdm.sv
// First-order sigma-delta PDM: carry of acc + sample on each ock edge.
// Optional input synchronizers on ock/uck via PDM_INPUT_SYNC_EN.
module pdm #(
  parameter int DW          = pdm_pkg::DW,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [DW-1:0] din,
  input  logic          signed_data,
  input  logic          uck,
  input  logic          ock,
  output logic          sdo
);
  import pdm_pkg::*;

  // Two's complement maps to offset binary by flipping the MSB
  localparam logic [DW-1:0] FLIP = {1'b1, {(DW-1){1'b0}}};

  logic          ock_p, uck_p;
  logic [DW-1:0] sample_q, acc_q;

  pdm_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ock (
    .clk(clk), .rstn(rstn), .d(ock), .pulse(ock_p)
  );
  pdm_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_uck (
    .clk(clk), .rstn(rstn), .d(uck), .pulse(uck_p)
  );

  // A coincident uck/ock pulse integrates the previously held sample
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sample_q <= '0;
      acc_q    <= '0;
      sdo      <= 1'b0;
    end else begin
      if (uck_p) sample_q <= din ^ (signed_data ? FLIP : '0);
      if (ock_p) {sdo, acc_q} <= {1'b0, acc_q} + {1'b0, sample_q};
    end
  end
endmodule

// File: tb/tb_pdm.sv
// Directed + randomized bench for pdm against a running-sum density model.
module tb_pdm;
  import pdm_pkg::*;

`ifdef PDM_INPUT_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif
  localparam int HOLD = 5;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] din = '0;
  logic        signed_data = 1'b0;
  logic        uck = 1'b0;
  logic        ock = 1'b0;
  logic        sdo;

  int checks = 0;
  int passed = 0;

  // Model: bit n = floor(T_n / 2^32) - floor(T_{n-1} / 2^32), T = sum of samples
  longint unsigned m_t = 0;
  longint unsigned m_s = 0;

  pdm dut (
    .clk(clk), .rstn(rstn), .din(din), .signed_data(signed_data),
    .uck(uck), .ock(ock), .sdo(sdo)
  );

  always #5 clk = ~clk;

  function automatic logic model_step();
    longint unsigned nt;
    nt = m_t + m_s;
    model_step = (nt >> 32) != (m_t >> 32);
    m_t = nt;
  endfunction

  task automatic check(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s: sdo=%0b expected %0b", tag, got, exp);
  endtask

  task automatic ock_pulse(input string tag);
    logic prev, exp;
    prev = sdo;
    exp  = model_step();
    ock  = 1'b1;
    repeat (LAT-1) @(negedge clk);
    check({tag, "_pre_lat"}, sdo, prev);
    @(negedge clk);
    check({tag, "_lat"}, sdo, exp);
    repeat (HOLD-LAT) @(negedge clk);
    ock = 1'b0;
    repeat (HOLD) @(negedge clk);
    check({tag, "_hold"}, sdo, exp);
  endtask

  task automatic load(input logic [31:0] d, input logic sg);
    din = d; signed_data = sg; uck = 1'b1;
    m_s = {32'd0, sg ? (d ^ SIGN_FLIP) : d};
    repeat (HOLD) @(negedge clk);
    uck = 1'b0;
    repeat (HOLD) @(negedge clk);
    // Scramble inputs with no uck edge; must have no effect
    din = $urandom; signed_data = 1'($urandom_range(0, 1));
  endtask

  task automatic both_pulse(input logic [31:0] d, input logic sg, input string tag);
    logic exp;
    exp = model_step();
    m_s = {32'd0, sg ? (d ^ SIGN_FLIP) : d};
    din = d; signed_data = sg; uck = 1'b1; ock = 1'b1;
    repeat (HOLD) @(negedge clk);
    check(tag, sdo, exp);
    uck = 1'b0; ock = 1'b0;
    repeat (HOLD) @(negedge clk);
  endtask

  task automatic do_reset();
    rstn = 1'b0; m_t = 0; m_s = 0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [31:0] rd;
    logic        rs;
    int          n;
    // Reset held while strobes toggle
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); ock = ~ock; uck = ~uck; din = $urandom;
      check("reset_hold", sdo, 1'b0);
    end
    ock = 1'b0; uck = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) ock_pulse("no_uck");

    load(32'h8000_0000, 1'b0);
    for (int i = 0; i < 8; i++) ock_pulse("half");
    do_reset();
    load(32'h4000_0000, 1'b0);
    for (int i = 0; i < 8; i++) ock_pulse("quarter");
    do_reset();
    load(32'hFFFF_FFFF, 1'b0);
    for (int i = 0; i < 256; i++) ock_pulse("full");
    do_reset();
    load(32'h0000_0000, 1'b0);
    for (int i = 0; i < 256; i++) ock_pulse("zero");

    do_reset();
    load(32'h0000_0000, 1'b1);
    for (int i = 0; i < 8; i++) ock_pulse("signed_zero");
    load(32'h8000_0000, 1'b1);
    for (int i = 0; i < 8; i++) ock_pulse("signed_min");

    // Coincident strobes: old sample (0) used, new one from the next pulse
    do_reset();
    load(32'h0000_0000, 1'b0);
    both_pulse(32'h8000_0000, 1'b0, "simul_old");
    for (int i = 0; i < 4; i++) ock_pulse("simul_after");

    // Mid-stream async reset while sdo=1
    do_reset();
    load(32'h8000_0000, 1'b0);
    ock_pulse("pre_rst");
    ock_pulse("pre_rst");
    #2 rstn = 1'b0; m_t = 0; m_s = 0;
    #1 check("async_rst", sdo, 1'b0);
    @(negedge clk); @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    load(32'h8000_0000, 1'b0);
    for (int i = 0; i < 4; i++) ock_pulse("post_rst");

    // Randomized sample/pulse mix, including coincident strobes
    for (int r = 0; r < 12; r++) begin
      rd = $urandom;
      rs = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) both_pulse(rd, rs, "rand_simul");
      else load(rd, rs);
      n = $urandom_range(4, 16);
      for (int i = 0; i < n; i++) ock_pulse("rand");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
